// File: rtl/nn_pkg.sv
// Shared constants and state encoding for the layer-1 address sequencer.
package nn_pkg;

  localparam int N_INPUTS  = 784;  // inputs per neuron (pixels per image)
  localparam int N_NEURONS = 200;  // layer-1 neurons
  localparam int IN_AW     = 10;   // input-SRAM address width
  localparam int W_AW      = 18;   // weight-SRAM address width
  localparam int N_AW      = 8;    // neuron index width

  // WAIT_MAC is only reachable when MAC_HANDSHAKE_EN is defined.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STREAM   = 2'd1,
    WAIT_MAC = 2'd2,
    FINISH   = 2'd3
  } state_t;

endpackage

// File: rtl/wrap_counter.sv
// Up-counter that wraps to 0 after reaching MAX; clr has priority over inc.
module wrap_counter #(
  parameter int W   = 8,
  parameter int MAX = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         at_max
);

  localparam logic [W-1:0] MAXV = W'(MAX);

  assign at_max = (count == MAXV);

  // Advance on inc, wrap at the terminal value.
  always_ff @(posedge clk) begin
    if (reset || clr)
      count <= '0;
    else if (inc)
      count <= at_max ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/mac_addr_sequencer.sv
// Layer-1 address sequencer: walks every (neuron i, input j) pair, driving the
// input-SRAM address j and weight-SRAM address i*N_INPUTS+j, and strobes
// mac_start with the last input of each neuron.
// Optional feature MAC_HANDSHAKE_EN: wait for mac_done after each neuron.
module mac_addr_sequencer
  import nn_pkg::*;
#(
  parameter int N_INPUTS  = nn_pkg::N_INPUTS,
  parameter int N_NEURONS = nn_pkg::N_NEURONS,
  parameter int IN_AW     = nn_pkg::IN_AW,
  parameter int W_AW      = nn_pkg::W_AW,
  parameter int N_AW      = nn_pkg::N_AW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             mac_done,
  output logic [IN_AW-1:0] in_addr,
  output logic [W_AW-1:0]  w_addr,
  output logic [N_AW-1:0]  neuron_idx,
  output logic             addr_valid,
  output logic             mac_start,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [IN_AW-1:0] j;
  logic [N_AW-1:0]  i;
  logic [W_AW-1:0]  w;
  logic             j_max, i_max;
  logic             step;     // present the pending (i,j) pair this edge
  logic             cnt_clr;

`ifdef MAC_HANDSHAKE_EN
  logic             last_q;   // the neuron being waited on is the final one
`else
  logic             unused_mac_done;
  assign unused_mac_done = mac_done;
`endif

  assign cnt_clr = (state == FINISH);

  // Decide whether the pending pair is presented on this edge.
  always_comb begin
    step = 1'b0;
    case (state)
      IDLE:     step = start;
      STREAM:   step = !pause;
`ifdef MAC_HANDSHAKE_EN
      // mac_done in the same cycle as mac_start is too early to count.
      WAIT_MAC: step = mac_done && !mac_start && !last_q;
`endif
      default:  step = 1'b0;
    endcase
  end

  wrap_counter #(.W(IN_AW), .MAX(N_INPUTS - 1)) u_j_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (step),
    .clr    (cnt_clr),
    .count  (j),
    .at_max (j_max)
  );

  wrap_counter #(.W(N_AW), .MAX(N_NEURONS - 1)) u_i_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (step && j_max),
    .clr    (cnt_clr),
    .count  (i),
    .at_max (i_max)
  );

  // Weight address tracks i*N_INPUTS+j as a plain running count.
  always_ff @(posedge clk) begin
    if (reset || cnt_clr)
      w <= '0;
    else if (step)
      w <= w + 1'b1;
  end

  // Control FSM with registered outputs; the output pair always shows the
  // pending element so a paused pair is re-presented unchanged on resume.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      in_addr    <= '0;
      w_addr     <= '0;
      neuron_idx <= '0;
      addr_valid <= 1'b0;
      mac_start  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef MAC_HANDSHAKE_EN
      last_q     <= 1'b0;
`endif
    end else begin
      addr_valid <= step;
      mac_start  <= step && j_max;
      done       <= 1'b0;
      if (state != IDLE) begin
        in_addr    <= j;
        w_addr     <= w;
        neuron_idx <= i;
      end
      if (step) begin
        in_addr    <= j;
        w_addr     <= w;
        neuron_idx <= i;
        busy       <= 1'b1;
        if (j_max) begin
`ifdef MAC_HANDSHAKE_EN
          state  <= WAIT_MAC;
          last_q <= i_max;
`else
          state  <= i_max ? FINISH : STREAM;
`endif
        end else begin
          state <= STREAM;
        end
      end else begin
        case (state)
`ifdef MAC_HANDSHAKE_EN
          WAIT_MAC: begin
            if (mac_done && !mac_start && last_q) begin
              state  <= FINISH;
              last_q <= 1'b0;
            end
          end
`endif
          FINISH: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mac_addr_sequencer.sv
// Bench for mac_addr_sequencer on a reduced 8-input x 4-neuron layer.
// Define MAC_HANDSHAKE_EN for the handshake build.
module tb_mac_addr_sequencer;

  localparam int NI  = 8;
  localparam int NN  = 4;
  localparam int TOT = NI * NN;
`ifdef MAC_HANDSHAKE_EN
  localparam int GAP = 6;   // 5 idle cycles at each neuron boundary
`else
  localparam int GAP = 1;   // back-to-back neurons
`endif
  localparam int LIM = 400;

  logic        clk = 1'b0;
  logic        reset, start, pause, mac_done;
  logic [9:0]  in_addr;
  logic [17:0] w_addr;
  logic [7:0]  neuron_idx;
  logic        addr_valid, mac_start, busy, done;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  int k    = 0;       // index of the next element the model expects
  bit in_pass = 1'b0;
  int last_v = -1;
  int done_cnt = 0;
  int md = 0;
  bit rst_seen = 1'b0;

  mac_addr_sequencer #(.N_INPUTS(NI), .N_NEURONS(NN)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pause      (pause),
    .mac_done   (mac_done),
    .in_addr    (in_addr),
    .w_addr     (w_addr),
    .neuron_idx (neuron_idx),
    .addr_valid (addr_valid),
    .mac_start  (mac_start),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    rst_seen <= reset;
  end

  // MAC stand-in: returns mac_done five cycles after each mac_start.
  always @(negedge clk) begin
    mac_done = 1'b0;
    if (md > 0) begin
      md--;
      if (md == 0) mac_done = 1'b1;
    end
    if (mac_start) md = 5;
  end

  // Model: element k of a pass is (i=k/NI, j=k%NI) at weight address k.
  always @(negedge clk) begin
    if (rst_seen) begin
      chk("reset_outputs",
          longint'({addr_valid, mac_start, busy, done, in_addr, w_addr, neuron_idx}), 0);
      k = 0;
      in_pass = 1'b0;
      last_v = -1;
    end else begin
      if (addr_valid) begin
        chk("elem_in_range", k < TOT, 1);
        chk("in_addr", in_addr, k % NI);
        chk("w_addr", w_addr, k);
        chk("neuron_idx", neuron_idx, k / NI);
        chk("mac_start", mac_start, (k % NI) == NI - 1);
        if (k % NI == 0 && k > 0) chk("boundary_gap", cyc - last_v, GAP);
        last_v = cyc;
        k++;
        in_pass = 1'b1;
      end else begin
        chk("mac_start_idle", mac_start, 0);
      end
      if (done) begin
        chk("done_after_all", k, TOT);
        k = 0;
        in_pass = 1'b0;
        done_cnt++;
      end
      chk("busy", busy, in_pass);
    end
  end

  initial begin
    int n;
    int c0;
    reset = 1'b1; start = 1'b0; pause = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_valid", addr_valid, 0);
    chk("idle_busy", busy, 0);

    // Pass 1: pause mid-neuron, stray starts while busy and in FINISH.
    start = 1'b1; c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("first_valid", addr_valid, 1);
    chk("first_in", in_addr, 0);
    chk("first_w", w_addr, 0);
    chk("first_mac_start", mac_start, 0);
    chk("first_busy", busy, 1);

    n = 0;
    while (!mac_start && n < LIM) begin @(negedge clk); n++; end
    if (n >= LIM) chk("tmo_mac_start", 0, 1);
    chk("first_strobe_w", w_addr, 7);
    chk("first_strobe_in", in_addr, 7);

    n = 0;
    while (!(addr_valid && neuron_idx == 1 && in_addr == 4) && n < LIM) begin
      @(negedge clk); n++;
    end
    if (n >= LIM) chk("tmo_pause_point", 0, 1);
    pause = 1'b1;
    @(negedge clk);
    chk("pause_valid", addr_valid, 0);
    chk("pause_hold_in", in_addr, 5);
    chk("pause_hold_w", w_addr, 13);
    @(negedge clk);
    @(negedge clk);
    chk("pause_hold_in2", in_addr, 5);
    pause = 1'b0;
    @(negedge clk);
    chk("resume_valid", addr_valid, 1);
    chk("resume_in", in_addr, 5);
    chk("resume_w", w_addr, 13);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    n = 0;
    while (!(addr_valid && neuron_idx == NN - 1 && in_addr == NI - 1) && n < LIM) begin
      @(negedge clk); n++;
    end
    if (n >= LIM) chk("tmo_final_elem", 0, 1);
    chk("final_w", w_addr, 31);
    chk("final_strobe", mac_start, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    n = 0;
    while (!done && n < LIM) begin @(negedge clk); n++; end
    if (n >= LIM) chk("tmo_done1", 0, 1);
`ifndef MAC_HANDSHAKE_EN
    chk("start_to_done", cyc - c0, 36);
`endif
    repeat (5) begin
      @(negedge clk);
      chk("no_restart_valid", addr_valid, 0);
      chk("no_restart_busy", busy, 0);
    end
    chk("done_count1", done_cnt, 1);

    // Pass 2: reset in the middle of neuron 2.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(addr_valid && neuron_idx == 2) && n < LIM) begin @(negedge clk); n++; end
    if (n >= LIM) chk("tmo_neuron2", 0, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("post_reset_valid", addr_valid, 0);
      chk("post_reset_done", done, 0);
    end
    chk("done_count_reset", done_cnt, 1);

    // Pass 3: clean restart from element 0.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_in", in_addr, 0);
    chk("restart_w", w_addr, 0);
    chk("restart_valid", addr_valid, 1);
    n = 0;
    while (!done && n < LIM) begin @(negedge clk); n++; end
    if (n >= LIM) chk("tmo_done3", 0, 1);
    repeat (3) @(negedge clk);
    chk("done_count2", done_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs + 1);
    $fatal(1, "watchdog");
  end

endmodule
